// File: rtl/rv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// rv_pipe_pkg
// Shared types for the RV32I pipeline hazard/forwarding controller.
//   reg_addr_t  : architectural register index
//   stage_ent_t : per-stage in-flight record {valid, rd, wb_en, is_load}
//   fwd_sel_t   : forwarding index/code, wide enough for any supported depth
//   fwd_code()  : converts a youngest-match stage index into an EX mux select
// -----------------------------------------------------------------------------
package rv_pipe_pkg;

  localparam int RA_W      = 5;
  localparam int MAX_SEL_W = 8;

  typedef logic [RA_W-1:0]      reg_addr_t;
  typedef logic [MAX_SEL_W-1:0] fwd_sel_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      wb_en;
    logic      is_load;
  } stage_ent_t;

  localparam stage_ent_t BUBBLE = '{valid: 1'b0, rd: '0, wb_en: 1'b0, is_load: 1'b0};

  // A producer found at stage k while the consumer sits in ID will be at
  // stage k+1 once the consumer reaches EX, so its select is k+1. The last
  // stage writes the regfile in the same cycle (write-first), hence 0.
  function automatic fwd_sel_t fwd_code(input logic hit, input fwd_sel_t idx,
                                        input int n_stg);
    fwd_sel_t code;
    code = '0;
    if (hit && (int'(idx) < n_stg - 1)) code = idx + fwd_sel_t'(1);
    return code;
  endfunction

endpackage

// File: rtl/rv_pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// rv_pipe_hazard_ctrl_if
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave). Signal suffixes are from the controller's point of view.
//   ID side   : id_valid_i, id_rs1_i/id_use_rs1_i, id_rs2_i/id_use_rs2_i,
//               id_rd_i/id_wb_en_i, id_is_load_i
//   control   : br_taken_i, cnt_clr_i
//   results   : stall_o, flush_o, fwd_rs1_o, fwd_rs2_o, stg_valid_o,
//               stall_cnt_o, flush_cnt_o
// -----------------------------------------------------------------------------
interface rv_pipe_hazard_ctrl_if #(
  parameter int N_STG = 3,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  localparam int SEL_W = $clog2(N_STG);

  logic             id_valid_i;
  logic [RA_W-1:0]  id_rs1_i;
  logic             id_use_rs1_i;
  logic [RA_W-1:0]  id_rs2_i;
  logic             id_use_rs2_i;
  logic [RA_W-1:0]  id_rd_i;
  logic             id_wb_en_i;
  logic             id_is_load_i;
  logic             br_taken_i;
  logic             cnt_clr_i;

  logic             stall_o;
  logic             flush_o;
  logic [SEL_W-1:0] fwd_rs1_o;
  logic [SEL_W-1:0] fwd_rs2_o;
  logic [N_STG-1:0] stg_valid_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_use_rs1_i, id_rs2_i, id_use_rs2_i,
           id_rd_i, id_wb_en_i, id_is_load_i, br_taken_i, cnt_clr_i,
    input  stall_o, flush_o, fwd_rs1_o, fwd_rs2_o, stg_valid_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_use_rs1_i, id_rs2_i, id_use_rs2_i,
           id_rd_i, id_wb_en_i, id_is_load_i, br_taken_i, cnt_clr_i,
    output stall_o, flush_o, fwd_rs1_o, fwd_rs2_o, stg_valid_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/rv_fwd_match.sv
// -----------------------------------------------------------------------------
// rv_fwd_match
// Combinational priority match of one source register against the in-flight
// entry array. The youngest (lowest-index) matching stage wins.
//   ents_i    : entry array, index 0 = EX
//   rs_i      : source register read in ID
//   use_i     : source is actually read
//   hit_o     : some stage will write rs_i
//   idx_o     : stage index of the youngest writer
//   is_load_o : youngest writer is a load
// -----------------------------------------------------------------------------
module rv_fwd_match
  import rv_pipe_pkg::*;
#(
  parameter int N_STG = 3
) (
  input  stage_ent_t [N_STG-1:0] ents_i,
  input  reg_addr_t              rs_i,
  input  logic                   use_i,
  output logic                   hit_o,
  output fwd_sel_t               idx_o,
  output logic                   is_load_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    hit_o     = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    // Scan oldest to youngest so the last (youngest) match overrides.
    for (int k = N_STG - 1; k >= 0; k--) begin
      if (use_i && ents_i[k].valid && ents_i[k].wb_en &&
          (ents_i[k].rd != '0) && (ents_i[k].rd == rs_i)) begin
        hit_o     = 1'b1;
        idx_o     = fwd_sel_t'(k);
        is_load_o = ents_i[k].is_load;
      end
    end
  end

endmodule

// File: rtl/rv_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// rv_pipe_hazard_ctrl
// Hazard and forwarding controller for an in-order RV32I pipeline with a
// configurable number of post-ID stages.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low
//   bus   : slave side of rv_pipe_hazard_ctrl_if (ID fields, branch, counter
//           clear in; stall, flush, forwarding selects, stage valids and
//           performance counters out)
// Parameters: N_STG post-ID stages (0 = EX, N_STG-1 = WB), LOAD_LAT load
// latency in stages, BR_STG branch-resolve stage, RA_W register index width,
// CNT_W counter width.
// -----------------------------------------------------------------------------
module rv_pipe_hazard_ctrl #(
  parameter int N_STG    = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_STG   = 2,
  parameter int RA_W     = 5,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  rv_pipe_hazard_ctrl_if.slave   bus
);

  import rv_pipe_pkg::*;

  localparam int SEL_W = $clog2(N_STG);

  stage_ent_t [N_STG-1:0] ent_q, ent_d;
  logic [SEL_W-1:0]       fwd1_q, fwd1_d;
  logic [SEL_W-1:0]       fwd2_q, fwd2_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;

  logic       m1_hit, m1_ld, m2_hit, m2_ld;
  fwd_sel_t   m1_idx, m2_idx;
  fwd_sel_t   code1, code2;
  logic       lh1, lh2;
  logic       stall, flush, issue;
  stage_ent_t id_ent;
  logic [N_STG-1:0] stg_valid;

  rv_fwd_match #(.N_STG(N_STG)) u_match_rs1 (
    .ents_i    (ent_q),
    .rs_i      (bus.id_rs1_i),
    .use_i     (bus.id_use_rs1_i),
    .hit_o     (m1_hit),
    .idx_o     (m1_idx),
    .is_load_o (m1_ld)
  );

  rv_fwd_match #(.N_STG(N_STG)) u_match_rs2 (
    .ents_i    (ent_q),
    .rs_i      (bus.id_rs2_i),
    .use_i     (bus.id_use_rs2_i),
    .hit_o     (m2_hit),
    .idx_o     (m2_idx),
    .is_load_o (m2_ld)
  );

  // A load's data is usable from stage LOAD_LAT+1; a consumer issued now
  // would see the load at stage idx+1, so idx < LOAD_LAT is too early.
  assign lh1 = m1_hit & m1_ld & (int'(m1_idx) < LOAD_LAT);
  assign lh2 = m2_hit & m2_ld & (int'(m2_idx) < LOAD_LAT);

  // A taken branch squashes ID anyway, so stalling it would be pointless.
  assign flush = bus.br_taken_i;
  assign stall = bus.id_valid_i & ~bus.br_taken_i & (lh1 | lh2);
  assign issue = bus.id_valid_i & ~stall & ~flush;

  assign id_ent = '{valid:   1'b1,
                    rd:      bus.id_rd_i,
                    wb_en:   bus.id_wb_en_i,
                    is_load: bus.id_is_load_i};

  assign code1 = fwd_code(m1_hit, m1_idx, N_STG);
  assign code2 = fwd_code(m2_hit, m2_idx, N_STG);

  always_comb begin
    ent_d  = ent_q;
    fwd1_d = '0;
    fwd2_d = '0;

    ent_d[0] = issue ? id_ent : BUBBLE;
    for (int k = 1; k < N_STG; k++) begin
      ent_d[k] = (flush && (k < BR_STG)) ? BUBBLE : ent_q[k-1];
    end

    if (issue) begin
      fwd1_d = code1[SEL_W-1:0];
      fwd2_d = code2[SEL_W-1:0];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the whole entry array is reset so no stale
  // destination can trigger a stall or forward after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q       <= '0;
      fwd1_q      <= '0;
      fwd2_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ent_q       <= ent_d;
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stg_valid = '0;
    for (int k = 0; k < N_STG; k++) stg_valid[k] = ent_q[k].valid;
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.fwd_rs1_o   = fwd1_q;
  assign bus.fwd_rs2_o   = fwd2_q;
  assign bus.stg_valid_o = stg_valid;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_rv_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv_pipe_hazard_ctrl
// Directed bench: instance A uses default parameters, instance B uses
// N_STG=5, LOAD_LAT=2 and a 2-bit counter so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_rv_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rv_pipe_hazard_ctrl_if #(.N_STG(3), .RA_W(5), .CNT_W(32)) bus_a ();
  rv_pipe_hazard_ctrl_if #(.N_STG(5), .RA_W(5), .CNT_W(2))  bus_b ();

  rv_pipe_hazard_ctrl #(.N_STG(3), .LOAD_LAT(1), .BR_STG(2), .RA_W(5), .CNT_W(32))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  rv_pipe_hazard_ctrl #(.N_STG(5), .LOAD_LAT(2), .BR_STG(2), .RA_W(5), .CNT_W(2))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wb, input logic ld);
    bus_a.id_valid_i   = v;
    bus_a.id_rs1_i     = rs1;
    bus_a.id_use_rs1_i = u1;
    bus_a.id_rs2_i     = rs2;
    bus_a.id_use_rs2_i = u2;
    bus_a.id_rd_i      = rd;
    bus_a.id_wb_en_i   = wb;
    bus_a.id_is_load_i = ld;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wb, input logic ld);
    bus_b.id_valid_i   = v;
    bus_b.id_rs1_i     = rs1;
    bus_b.id_use_rs1_i = u1;
    bus_b.id_rs2_i     = rs2;
    bus_b.id_use_rs2_i = u2;
    bus_b.id_rd_i      = rd;
    bus_b.id_wb_en_i   = wb;
    bus_b.id_is_load_i = ld;
  endtask

  initial begin
    rst = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);
    bus_a.br_taken_i = 1'b0; bus_a.cnt_clr_i = 1'b0;
    bus_b.br_taken_i = 1'b0; bus_b.cnt_clr_i = 1'b0;

    // Reset state
    #12;
    check("rst_stall",     bus_a.stall_o, 0);
    check("rst_flush",     bus_a.flush_o, 0);
    check("rst_stg_valid", bus_a.stg_valid_o, 0);
    check("rst_fwd1",      bus_a.fwd_rs1_o, 0);
    check("rst_fwd2",      bus_a.fwd_rs2_o, 0);
    check("rst_stall_cnt", bus_a.stall_cnt_o, 0);
    check("rst_flush_cnt", bus_a.flush_cnt_o, 0);
    check("rst_b_valid",   bus_b.stg_valid_o, 0);
    rst = 1'b1;
    tick();

    // ALU chain: ADD x5; ADD x6,x5,x1; I3 reads x5 via rs2; I4 reads x5 third-back
    drive_a(1, 0, 0, 0, 0, 5, 1, 0);
    #1 check("alu1_stall", bus_a.stall_o, 0);
    tick();
    drive_a(1, 5, 1, 1, 1, 6, 1, 0);
    #1 check("alu2_stall", bus_a.stall_o, 0);
    tick();
    check("alu2_fwd1",  bus_a.fwd_rs1_o, 1);
    check("alu2_fwd2",  bus_a.fwd_rs2_o, 0);
    check("alu2_valid", bus_a.stg_valid_o, 3'b011);
    drive_a(1, 0, 0, 5, 1, 7, 1, 0);
    #1 check("alu3_stall", bus_a.stall_o, 0);
    tick();
    check("alu3_fwd2",  bus_a.fwd_rs2_o, 2);
    check("alu3_fwd1",  bus_a.fwd_rs1_o, 0);
    check("alu3_valid", bus_a.stg_valid_o, 3'b111);
    drive_a(1, 5, 1, 0, 0, 8, 1, 0);
    tick();
    check("alu4_third_back_fwd1", bus_a.fwd_rs1_o, 0);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("drain_valid", bus_a.stg_valid_o, 0);

    // Load-use: LW x5; ADD x6,x5,x0
    drive_a(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    drive_a(1, 5, 1, 0, 1, 6, 1, 0);
    #1 check("lu_stall", bus_a.stall_o, 1);
    tick();
    check("lu_stall_cnt", bus_a.stall_cnt_o, 1);
    check("lu_bubble",    bus_a.stg_valid_o, 3'b010);
    check("lu_bub_fwd1",  bus_a.fwd_rs1_o, 0);
    check("lu_release",   bus_a.stall_o, 0);
    tick();
    check("lu_fwd1",       bus_a.fwd_rs1_o, 2);
    check("lu_valid",      bus_a.stg_valid_o, 3'b101);
    check("lu_stall_cnt2", bus_a.stall_cnt_o, 1);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // x0 destination and unused source flags
    drive_a(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    drive_a(1, 0, 1, 0, 1, 8, 1, 0);
    #1 check("x0_stall", bus_a.stall_o, 0);
    tick();
    check("x0_fwd1", bus_a.fwd_rs1_o, 0);
    check("x0_fwd2", bus_a.fwd_rs2_o, 0);
    drive_a(1, 0, 0, 0, 0, 9, 1, 1);
    tick();
    drive_a(1, 9, 0, 9, 0, 10, 1, 0);
    #1 check("nouse_stall", bus_a.stall_o, 0);
    tick();
    check("nouse_fwd1", bus_a.fwd_rs1_o, 0);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Taken branch with stages 0 and 1 valid
    drive_a(1, 0, 0, 0, 0, 10, 1, 0);
    tick();
    drive_a(1, 0, 0, 0, 0, 11, 1, 0);
    tick();
    check("br_pre_valid", bus_a.stg_valid_o, 3'b011);
    drive_a(1, 0, 0, 0, 0, 12, 1, 0);
    bus_a.br_taken_i = 1'b1;
    #1 check("br_flush", bus_a.flush_o, 1);
    check("br_no_stall", bus_a.stall_o, 0);
    tick();
    check("br_valid",     bus_a.stg_valid_o, 3'b100);
    check("br_flush_cnt", bus_a.flush_cnt_o, 1);
    bus_a.br_taken_i = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("br_flush_off", bus_a.flush_o, 0);
    repeat (3) tick();

    // Load-use coinciding with a taken branch: flush dominates
    drive_a(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    drive_a(1, 5, 1, 0, 0, 6, 1, 0);
    bus_a.br_taken_i = 1'b1;
    #1 check("lubr_stall", bus_a.stall_o, 0);
    check("lubr_flush", bus_a.flush_o, 1);
    tick();
    check("lubr_flush_cnt", bus_a.flush_cnt_o, 2);
    check("lubr_stall_cnt", bus_a.stall_cnt_o, 1);

    // Clear wins over a simultaneous increment
    bus_a.cnt_clr_i = 1'b1;
    tick();
    bus_a.br_taken_i = 1'b0;
    bus_a.cnt_clr_i  = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    check("clr_flush_cnt", bus_a.flush_cnt_o, 0);
    check("clr_stall_cnt", bus_a.stall_cnt_o, 0);

    // Deep pipe, LOAD_LAT=2: two stall cycles, then forward from stage 2
    drive_b(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    drive_b(1, 5, 1, 0, 0, 6, 1, 0);
    #1 check("b_stall_c1", bus_b.stall_o, 1);
    tick();
    check("b_stall_c2",  bus_b.stall_o, 1);
    check("b_cnt1",      bus_b.stall_cnt_o, 1);
    tick();
    check("b_stall_end", bus_b.stall_o, 0);
    check("b_cnt2",      bus_b.stall_cnt_o, 2);
    tick();
    check("b_fwd1", bus_b.fwd_rs1_o, 3);
    check("b_cnt2_hold", bus_b.stall_cnt_o, 2);

    // Second load-use drives the 2-bit counter into saturation
    drive_b(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    drive_b(1, 0, 0, 7, 1, 8, 1, 0);
    #1 check("b2_stall", bus_b.stall_o, 1);
    tick();
    check("b2_cnt3", bus_b.stall_cnt_o, 3);
    tick();
    check("b2_stall_end", bus_b.stall_o, 0);
    check("b2_cnt_sat",   bus_b.stall_cnt_o, 3);
    tick();

    // Third load-use: reset asserted asynchronously mid-stall
    drive_b(1, 0, 0, 0, 0, 8, 1, 1);
    tick();
    drive_b(1, 8, 1, 0, 0, 9, 1, 0);
    #1 check("b3_stall", bus_b.stall_o, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_stall",     bus_b.stall_o, 0);
    check("arst_flush",     bus_b.flush_o, 0);
    check("arst_valid",     bus_b.stg_valid_o, 0);
    check("arst_fwd1",      bus_b.fwd_rs1_o, 0);
    check("arst_fwd2",      bus_b.fwd_rs2_o, 0);
    check("arst_stall_cnt", bus_b.stall_cnt_o, 0);
    check("arst_flush_cnt", bus_b.flush_cnt_o, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    tick();
    check("post_rst_valid", bus_b.stg_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
